// File: rtl/project_id_shifter.sv
`default_nettype none
// ============================================================================
// Module      : project_id_shifter
// Description : Latches the project ID once after reset and shifts it out
//               MSB-first on a serial_clock/serial_data/serial_load bus.
// Revision    : 1.0 - initial release
// ============================================================================
module project_id_shifter #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic [WIDTH-1:0] project_id,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             serial_clock,
  output logic             serial_data,
  output logic             serial_load,
  output logic [WIDTH-1:0] id_latched,
  output logic             id_valid
);

  localparam int c_div_w = $clog2(2 * CLK_DIV);
  localparam int c_bit_w = $clog2(WIDTH + 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(2 * CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_CAPTURE = 2'd0,
    S_IDLE    = 2'd1,
    S_SHIFT   = 2'd2,
    S_LOAD    = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic [WIDTH-1:0]   r_shreg, w_shreg;
  logic [c_div_w-1:0] r_div, w_div;
  logic [c_bit_w-1:0] r_bit, w_bit;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_sclk, w_sclk;
  logic               r_sdata, w_sdata;
  logic               r_sload, w_sload;
  logic [WIDTH-1:0]   r_id, w_id;
  logic               r_idv, w_idv;
  logic [WIDTH-1:0]   w_shifted;

  assign w_shifted = r_shreg << 1;

  // Every output is a register; this block only computes their next values.
  always_comb begin
    w_state = r_state;
    w_shreg = r_shreg;
    w_div   = r_div;
    w_bit   = r_bit;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_sclk  = r_sclk;
    w_sdata = r_sdata;
    w_sload = r_sload;
    w_id    = r_id;
    w_idv   = r_idv;
    case (r_state)
      S_CAPTURE: begin
        w_id    = project_id;
        w_idv   = 1'b1;
        w_state = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          w_shreg = r_id;
          w_sdata = r_id[WIDTH-1];
          w_busy  = 1'b1;
          w_div   = '0;
          w_bit   = '0;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_div = r_div + 1'b1;
        if (r_div == c_div_half) begin
          w_sclk = 1'b1;
        end
        // End of the high phase: advance to the next bit while the clock drops.
        if (r_div == c_div_last) begin
          w_div   = '0;
          w_sclk  = 1'b0;
          w_shreg = w_shifted;
          w_sdata = w_shifted[WIDTH-1];
          w_bit   = r_bit + 1'b1;
          if (r_bit == c_bit_last) begin
            w_sdata = 1'b0;
            w_sload = 1'b1;
            w_state = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_div = r_div + 1'b1;
        if (r_div == c_div_half) begin
          w_div   = '0;
          w_sload = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_CAPTURE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state <= S_CAPTURE;
      r_shreg <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_sload <= 1'b0;
      r_id    <= '0;
      r_idv   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shreg <= w_shreg;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_sclk  <= w_sclk;
      r_sdata <= w_sdata;
      r_sload <= w_sload;
      r_id    <= w_id;
      r_idv   <= w_idv;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign serial_clock = r_sclk;
  assign serial_data  = r_sdata;
  assign serial_load  = r_sload;
  assign id_latched   = r_id;
  assign id_valid     = r_idv;

endmodule
`default_nettype wire
